// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory client port among four req/grt requesters.
// Optional grant-hold watchdog with Timeout pulse compiled in by MEMARB_WATCHDOG_EN.
//
// state  | meaning
// S_IDLE | no grant; memory outputs forced to 0; arbitrate on any Req
// S_GRANT| exactly one Grt bit high; owner's bus slice routed to memory
module mem_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NREQ-1:0]  Req,
  input  logic [127:0]     ReqWriteBus,
  input  logic [127:0]     ReqAddrBus,
  input  logic [7:0]       ReqWDMB,
  input  logic [7:0]       ReqRDMB,
  output logic [NREQ-1:0]  Grt,
  output logic [31:0]      MemWriteBus,
  output logic [31:0]      MemAddrBus,
  output logic [1:0]       WDMB,
  output logic [1:0]       RDMB,
  output logic [1:0]       Owner,
  output logic             Busy
`ifdef MEMARB_WATCHDOG_EN
  ,
  output logic             Timeout
`endif
);

  if (NREQ != 4) begin : g_bad_nreq
    $error("mem_bus_arbiter supports exactly four requesters");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("MAX_HOLD must fit the 8-bit hold counter");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grt_q, grt_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            in_grant;

`ifdef MEMARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Circular search starting one past the previous grantee; k=4 wraps back to last_q itself.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && Req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef MEMARB_WATCHDOG_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|Req) begin
          state_d = S_GRANT;
          grt_d   = 4'b0001 << winner;
          owner_d = winner;
          last_d  = winner;
`ifdef MEMARB_WATCHDOG_EN
          hold_d  = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!Req[owner_q]) begin
          state_d = S_IDLE;
          grt_d   = '0;
        end
`ifdef MEMARB_WATCHDOG_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = S_IDLE;
          grt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        grt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      grt_q   <= '0;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
`ifdef MEMARB_WATCHDOG_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef MEMARB_WATCHDOG_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign in_grant    = (state_q == S_GRANT);
  assign MemWriteBus = in_grant ? ReqWriteBus[{owner_q, 5'b0} +: 32] : 32'd0;
  assign MemAddrBus  = in_grant ? ReqAddrBus[{owner_q, 5'b0} +: 32]  : 32'd0;
  assign WDMB        = in_grant ? ReqWDMB[{owner_q, 1'b0} +: 2]      : 2'd0;
  assign RDMB        = in_grant ? ReqRDMB[{owner_q, 1'b0} +: 2]      : 2'd0;
  assign Grt         = grt_q;
  assign Owner       = owner_q;
  assign Busy        = |grt_q;
`ifdef MEMARB_WATCHDOG_EN
  assign Timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a queue-based reference model predicts each cycle,
// a negedge monitor pops and compares. Watchdog scenarios follow MEMARB_WATCHDOG_EN.
module tb_mem_bus_arbiter;
`ifdef MEMARB_WATCHDOG_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 64;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [3:0]   Req = '0;
  logic [127:0] ReqWriteBus = '0;
  logic [127:0] ReqAddrBus = '0;
  logic [7:0]   ReqWDMB = '0;
  logic [7:0]   ReqRDMB = '0;
  logic [3:0]   Grt;
  logic [31:0]  MemWriteBus, MemAddrBus;
  logic [1:0]   WDMB, RDMB, Owner;
  logic         Busy;
  logic         to_act;
`ifdef MEMARB_WATCHDOG_EN
  logic         Timeout;
  assign to_act = Timeout;
`else
  assign to_act = 1'b0;
`endif

  always #5 Clk = ~Clk;

  mem_bus_arbiter #(.NREQ(4), .MAX_HOLD(HOLD)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req),
    .ReqWriteBus(ReqWriteBus), .ReqAddrBus(ReqAddrBus),
    .ReqWDMB(ReqWDMB), .ReqRDMB(ReqRDMB),
    .Grt(Grt), .MemWriteBus(MemWriteBus), .MemAddrBus(MemAddrBus),
    .WDMB(WDMB), .RDMB(RDMB), .Owner(Owner), .Busy(Busy)
`ifdef MEMARB_WATCHDOG_EN
    , .Timeout(Timeout)
`endif
  );

  typedef struct packed {
    logic [3:0]  grt;
    logic [1:0]  owner;
    logic        busy;
    logic [31:0] wr;
    logic [31:0] addr;
    logic [1:0]  wdmb;
    logic [1:0]  rdmb;
    logic        to;
  } snap_t;

  snap_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who holds the bus, who had it last, how long it has been held.
  bit m_granted = 0;
  int m_owner = 0;
  int m_last = 3;
  int m_hold = 0;
  bit m_to = 0;

  // Requester agents
  bit want[4];
  int hold_left[4];

  task automatic step();
    snap_t e;
    bit    found;
    int    c;
    e.grt   = m_granted ? 4'(1 << m_owner) : 4'b0;
    e.owner = 2'(m_owner);
    e.busy  = m_granted;
    e.wr    = m_granted ? ReqWriteBus[32*m_owner +: 32] : 32'd0;
    e.addr  = m_granted ? ReqAddrBus[32*m_owner +: 32]  : 32'd0;
    e.wdmb  = m_granted ? ReqWDMB[2*m_owner +: 2]       : 2'd0;
    e.rdmb  = m_granted ? ReqRDMB[2*m_owner +: 2]       : 2'd0;
    e.to    = m_to;
    sb.push_back(e);
    m_to = 0;
    if (Rst) begin
      m_granted = 0; m_owner = 0; m_last = 3; m_hold = 0;
    end else if (!m_granted) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && Req[c]) begin
          found = 1; m_granted = 1; m_owner = c; m_last = c; m_hold = 0;
        end
      end
    end else if (!Req[m_owner]) begin
      m_granted = 0;
    end
`ifdef MEMARB_WATCHDOG_EN
    else if (m_hold == HOLD - 1) begin
      m_granted = 0; m_to = 1;
    end else begin
      m_hold++;
    end
`endif
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Req = '0; ReqWriteBus = '0; ReqAddrBus = '0; ReqWDMB = '0; ReqRDMB = '0;
  endtask

  task automatic run_random(input int n, input int raise_pct, input int hmin,
                            input int hmax, input int rst_pm);
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_granted && m_owner == i && want[i]) begin
          if (hold_left[i] <= 1) want[i] = 0;
          else hold_left[i]--;
        end else if (!want[i] && $urandom_range(99) < raise_pct) begin
          want[i] = 1;
          hold_left[i] = $urandom_range(hmax, hmin);
        end
      end
      Req = {want[3], want[2], want[1], want[0]};
      ReqWriteBus = {$urandom, $urandom, $urandom, $urandom};
      ReqAddrBus  = {$urandom, $urandom, $urandom, $urandom};
      ReqWDMB = 8'($urandom);
      ReqRDMB = 8'($urandom);
      Rst = ($urandom_range(999) < rst_pm);
      step();
      Rst = 1'b0;
    end
  endtask

  initial begin : monitor
    snap_t e, a;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{Grt, Owner, Busy, MemWriteBus, MemAddrBus, WDMB, RDMB, to_act};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_state t=%0t actual grt=%b owner=%0d busy=%b wr=%h addr=%h wdmb=%0d rdmb=%0d to=%b required grt=%b owner=%0d busy=%b wr=%h addr=%h wdmb=%0d rdmb=%0d to=%b",
                   $time, a.grt, a.owner, a.busy, a.wr, a.addr, a.wdmb, a.rdmb, a.to,
                   e.grt, e.owner, e.busy, e.wr, e.addr, e.wdmb, e.rdmb, e.to);
        end
      end
    end
  end

  initial begin : driver
    @(posedge Clk);
    #1;
    step();                      // reset state with Rst still high
    Rst = 1'b0;

    // Single requester read at 0x8000, then release
    Req = 4'b0001; ReqAddrBus[31:0] = 32'h8000; ReqRDMB[1:0] = 2'd1;
    repeat (3) step();
    Req = 4'b0000;
    repeat (2) step();
    clear_inputs();

    // All four requesting, each holding three cycles once granted
    for (int i = 0; i < 4; i++) begin want[i] = 0; hold_left[i] = 0; end
    run_random(30, 100, 3, 3, 0);
    for (int i = 0; i < 4; i++) want[i] = 0;
    clear_inputs();
    repeat (2) step();

    // Requester 2 holds; requester 1 asks mid-grant and must wait
    Req = 4'b0100; ReqAddrBus[95:64] = 32'hA2A2_0002;
    repeat (3) step();
    Req = 4'b0110; ReqAddrBus[63:32] = 32'hA1A1_0001;
    repeat (4) step();
    Req = 4'b0010;
    repeat (4) step();
    clear_inputs();
    repeat (2) step();

    // Reset during a write grant to requester 3, then 0 and 3 compete
    Req = 4'b1000; ReqWDMB[7:6] = 2'd3; ReqWriteBus[127:96] = 32'hDEAD_BEEF;
    repeat (3) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    Req = 4'b1001;
    repeat (3) step();
    clear_inputs();
    repeat (2) step();

    // Requester 1 holds while 3 waits (watchdog revokes when compiled in)
    Req = 4'b1010;
    repeat (HOLD + 6) step();
    clear_inputs();
    repeat (2) step();

    // Long single-requester hold
    Req = 4'b0001;
    repeat (1000) step();
    clear_inputs();
    repeat (2) step();

    // Randomized traffic with occasional resets and same-cycle drop/raise
    for (int i = 0; i < 4; i++) want[i] = 0;
    run_random(3000, 30, 1, 6, 5);
    run_random(1000, 80, 1, 3, 0);
    clear_inputs();
    repeat (2) step();

    @(negedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual %0d entries left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
